// File: rtl/swipt_drive_gen_pkg.sv
// Constants and FSM encoding for the SWIPT drive generator.
// The sweep block uses the same frequency limits.
package swipt_drive_gen_pkg;

    localparam int FREQ_W = 20;

    localparam logic [FREQ_W-1:0] FREQ_MIN = 20'h088B8;
    localparam logic [FREQ_W-1:0] FREQ_MAX = 20'h0AFC8;
    localparam logic [FREQ_W-1:0] FREQ_DEFAULT = 20'h088B8;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_A_ON,
        ST_DEAD_AB,
        ST_B_ON,
        ST_DEAD_BA
    } drv_state_t;

endpackage

// File: rtl/swipt_drive_gen_if.sv
// Control and status bundle between the sweep logic and the
// half-bridge drive generator.
interface swipt_drive_gen_if;
    import swipt_drive_gen_pkg::*;

    logic              enable;
    logic [FREQ_W-1:0] freq_in;
    logic              drive_a;
    logic              drive_b;
    logic [FREQ_W-1:0] freq_applied;
    logic              period_tick;
    logic              freq_switched;
    logic              freq_err;

    modport master (
        output enable,
        output freq_in,
        input  drive_a,
        input  drive_b,
        input  freq_applied,
        input  period_tick,
        input  freq_switched,
        input  freq_err
    );

    modport slave (
        input  enable,
        input  freq_in,
        output drive_a,
        output drive_b,
        output freq_applied,
        output period_tick,
        output freq_switched,
        output freq_err
    );

endinterface

// File: rtl/swipt_drive_gen_deadtime.sv
// Complementary gate sequencer with dead-time insertion.
// Gate outputs are registered decodes of the next state.
module swipt_drive_gen_deadtime
    import swipt_drive_gen_pkg::*;
#(
    parameter int DEAD_CYC = 20
) (
    input  logic clk,
    input  logic nrst,
    input  logic enable,
    input  logic sq,
    output logic drive_a,
    output logic drive_b,
    output logic running
);

    localparam int CW = $clog2(DEAD_CYC + 1);
    localparam logic [CW-1:0] LOAD = CW'(DEAD_CYC - 1);

    drv_state_t    state;
    drv_state_t    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          a_n;
    logic          b_n;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= ST_OFF;
            cnt     <= '0;
            drive_a <= 1'b0;
            drive_b <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            drive_a <= a_n;
            drive_b <= b_n;
        end
    end

    // Dead counter keeps running if sq flips; target picked at expiry
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!enable) begin
            state_n = ST_OFF;
            cnt_n   = '0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_n = ST_DEAD_BA;
                    cnt_n   = LOAD;
                end
                ST_A_ON: begin
                    if (sq) begin
                        state_n = ST_DEAD_AB;
                        cnt_n   = LOAD;
                    end
                end
                ST_B_ON: begin
                    if (!sq) begin
                        state_n = ST_DEAD_BA;
                        cnt_n   = LOAD;
                    end
                end
                ST_DEAD_AB, ST_DEAD_BA: begin
                    if (cnt == '0) begin
                        state_n = sq ? ST_B_ON : ST_A_ON;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = ST_OFF;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_comb begin
        a_n = (state_n == ST_A_ON);
        b_n = (state_n == ST_B_ON);
    end

    assign running = (state != ST_OFF);

endmodule

// File: rtl/swipt_drive_gen.sv
// NCO-based SWIPT half-bridge drive generator; frequency
// changes are deferred to the next accumulator wrap.
module swipt_drive_gen #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int ACC_W = 32,
    parameter int unsigned INC_MULT = 32'(
        ((64'd1 << (ACC_W + 16)) + 64'(CLK_HZ / 2))
        / 64'(CLK_HZ)),
    parameter logic [19:0] FREQ_MIN =
        swipt_drive_gen_pkg::FREQ_MIN,
    parameter logic [19:0] FREQ_MAX =
        swipt_drive_gen_pkg::FREQ_MAX,
    parameter logic [19:0] FREQ_DEFAULT =
        swipt_drive_gen_pkg::FREQ_DEFAULT,
    parameter int DEAD_CYC = 20
) (
    input logic clk,
    input logic nrst,
    swipt_drive_gen_if.slave bus
);
    import swipt_drive_gen_pkg::*;

    function automatic logic [ACC_W-1:0] inc_of(
        input logic [FREQ_W-1:0] f
    );
        return ACC_W'((64'(f) * 64'(INC_MULT)) >> 16);
    endfunction

    logic [ACC_W-1:0]  phase;
    logic [ACC_W-1:0]  inc;
    logic [ACC_W-1:0]  sum;
    logic              carry;
    logic [FREQ_W-1:0] freq_applied;
    logic [FREQ_W-1:0] pending;
    logic [FREQ_W-1:0] cmp;
    logic [FREQ_W-1:0] start_freq;
    logic              pend_flag;
    logic              freq_err;
    logic              period_tick;
    logic              freq_switched;
    logic              running;
    logic              active;
    logic              sq;
    logic              valid;
    logic              wrap;
    logic              do_switch;
    logic              new_req;
    logic              drive_a;
    logic              drive_b;

    assign {carry, sum} = {1'b0, phase} + {1'b0, inc};
    assign sq = phase[ACC_W-1];
    assign active = running && bus.enable;
    assign valid = (bus.freq_in >= FREQ_MIN)
                && (bus.freq_in <= FREQ_MAX);
    assign start_freq = valid ? bus.freq_in : FREQ_DEFAULT;
    assign wrap = active && carry;
    assign do_switch = wrap && pend_flag;

    // On a switching wrap the request is judged against what becomes
    // applied, so a value already pending is not re-queued.
    assign cmp = do_switch ? pending : freq_applied;
    assign new_req = active && valid && (bus.freq_in != cmp);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            phase         <= '0;
            inc           <= inc_of(FREQ_DEFAULT);
            freq_applied  <= FREQ_DEFAULT;
            pending       <= FREQ_DEFAULT;
            pend_flag     <= 1'b0;
            freq_err      <= 1'b0;
            period_tick   <= 1'b0;
            freq_switched <= 1'b0;
        end else begin
            period_tick   <= wrap;
            freq_switched <= do_switch;
            if (!bus.enable) begin
                phase     <= '0;
                pend_flag <= 1'b0;
                freq_err  <= 1'b0;
            end else if (!running) begin
                phase        <= '0;
                freq_applied <= start_freq;
                inc          <= inc_of(start_freq);
                if (!valid) freq_err <= 1'b1;
            end else begin
                phase <= sum;
                if (!valid) freq_err <= 1'b1;
                if (do_switch) begin
                    freq_applied <= pending;
                    inc          <= inc_of(pending);
                    pend_flag    <= 1'b0;
                end
                if (new_req) begin
                    pending   <= bus.freq_in;
                    pend_flag <= 1'b1;
                end
            end
        end
    end

    swipt_drive_gen_deadtime #(
        .DEAD_CYC(DEAD_CYC)
    ) u_deadtime (
        .clk    (clk),
        .nrst   (nrst),
        .enable (bus.enable),
        .sq     (sq),
        .drive_a(drive_a),
        .drive_b(drive_b),
        .running(running)
    );

    assign bus.drive_a       = drive_a;
    assign bus.drive_b       = drive_b;
    assign bus.freq_applied  = freq_applied;
    assign bus.period_tick   = period_tick;
    assign bus.freq_switched = freq_switched;
    assign bus.freq_err      = freq_err;

endmodule

// File: tb/tb_swipt_drive_gen.sv
// Scenario bench for swipt_drive_gen with a frequency-switch
// scoreboard and continuous gate-overlap/dead-time monitor.
module tb_swipt_drive_gen;
    import swipt_drive_gen_pkg::*;

    localparam int DEAD_CYC = 20;

    logic clk = 1'b0;
    logic nrst;

    swipt_drive_gen_if bus();

    swipt_drive_gen #(
        .DEAD_CYC(DEAD_CYC)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_ticks = 0;
    int last_tick = 0;
    int last_period = 0;
    int a_run = 0;
    int b_run = 0;
    int last_a_len = 0;
    int last_b_len = 0;
    int low_run = 0;
    int cur = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    logic [19:0] exp_q[$];
    logic [19:0] exp_f;

    // Monitor: overlap, dead time, pulse lengths, ticks, scoreboard
    initial forever begin
        @(negedge clk);
        cyc++;
        n_checks++;
        if (bus.drive_a === 1'b1 && bus.drive_b === 1'b1) begin
            n_fail++;
            $display("FAIL overlap cyc=%0d got a=1 b=1 want not both",
                     cyc);
        end
        if (bus.drive_a === 1'b1 || bus.drive_b === 1'b1) begin
            if (!prev_a && !prev_b) begin
                n_checks++;
                if (low_run < DEAD_CYC) begin
                    n_fail++;
                    $display("FAIL dead_time cyc=%0d got=%0d want>=%0d",
                             cyc, low_run, DEAD_CYC);
                end
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        if (bus.drive_a === 1'b1) a_run++;
        else if (prev_a) begin last_a_len = a_run; a_run = 0; end
        if (bus.drive_b === 1'b1) b_run++;
        else if (prev_b) begin last_b_len = b_run; b_run = 0; end
        prev_a = (bus.drive_a === 1'b1);
        prev_b = (bus.drive_b === 1'b1);
        if (bus.period_tick === 1'b1) begin
            last_period = cyc - last_tick;
            last_tick = cyc;
            n_ticks++;
        end
        if (bus.freq_switched === 1'b1) begin
            n_checks++;
            if (bus.period_tick !== 1'b1) begin
                n_fail++;
                $display("FAIL switch_tick got=%b want=1",
                         bus.period_tick);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL switch_unexpected got=%0d want=none",
                         bus.freq_applied);
            end else begin
                exp_f = exp_q.pop_front();
                if (bus.freq_applied !== exp_f) begin
                    n_fail++;
                    $display("FAIL switch_freq got=%0d want=%0d",
                             bus.freq_applied, exp_f);
                end
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ticks(input int k, output bit ok);
        int t0;
        t0 = n_ticks;
        ok = 1'b0;
        for (int i = 0; i < 4000 * k; i++) begin
            clk_n(1);
            if (n_ticks >= t0 + k) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.enable = 1'b0;
        bus.freq_in = 20'd40000;
        clk_n(3);
        n_checks++;
        if (bus.drive_a !== 1'b0 || bus.drive_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drive got=%b%b want=00",
                     bus.drive_a, bus.drive_b);
        end
        n_checks++;
        if (bus.freq_applied !== 20'd35000) begin
            n_fail++;
            $display("FAIL reset_freq got=%0d want=35000",
                     bus.freq_applied);
        end
        n_checks++;
        if (bus.period_tick !== 1'b0 || bus.freq_switched !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses got=%b%b want=00",
                     bus.period_tick, bus.freq_switched);
        end
        n_checks++;
        if (bus.freq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err got=%b want=0", bus.freq_err);
        end
        nrst = 1'b1;
        clk_n(2);
    endtask

    task automatic test_start();
        int n;
        bit got;
        bit saw_b;
        bit ok;
        n = 0; got = 1'b0; saw_b = 1'b0;
        bus.freq_in = 20'd40000;
        bus.enable = 1'b1;
        cur = 40000;
        for (int i = 0; i < 100; i++) begin
            clk_n(1);
            n++;
            if (bus.drive_b === 1'b1) saw_b = 1'b1;
            if (bus.drive_a === 1'b1) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got || n != DEAD_CYC + 1 || saw_b) begin
            n_fail++;
            $display("FAIL start_latency got=%0d want=%0d",
                     got ? n : -1, DEAD_CYC + 1);
        end
        n_checks++;
        if (bus.freq_applied !== 20'd40000 || bus.freq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL start_freq got=%0d/%b want=40000/0",
                     bus.freq_applied, bus.freq_err);
        end
        wait_ticks(3, ok);
        n_checks++;
        if (!ok || last_period < 2499 || last_period > 2501) begin
            n_fail++;
            $display("FAIL period_40k got=%0d want=2500+-1",
                     ok ? last_period : -1);
        end
        n_checks++;
        if (last_a_len < 1228 || last_a_len > 1232 ||
            last_b_len < 1228 || last_b_len > 1232) begin
            n_fail++;
            $display("FAIL pulse_40k got=%0d/%0d want=1230+-2",
                     last_a_len, last_b_len);
        end
    endtask

    task automatic test_sweep_step();
        bit ok;
        wait_ticks(1, ok);
        clk_n(600);
        bus.freq_in = 20'd40050;
        exp_q.push_back(20'd40050);
        cur = 40050;
        clk_n(5);
        n_checks++;
        if (bus.freq_applied !== 20'd40000) begin
            n_fail++;
            $display("FAIL step_hold got=%0d want=40000",
                     bus.freq_applied);
        end
        wait_ticks(1, ok);
        n_checks++;
        if (!ok || last_period < 2499 || last_period > 2501) begin
            n_fail++;
            $display("FAIL step_old_period got=%0d want=2500+-1",
                     ok ? last_period : -1);
        end
        n_checks++;
        if (bus.freq_applied !== 20'd40050 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL step_applied got=%0d want=40050",
                     bus.freq_applied);
        end
        wait_ticks(2, ok);
        n_checks++;
        if (!ok || last_period < 2496 || last_period > 2498) begin
            n_fail++;
            $display("FAIL step_new_period got=%0d want=2497+-1",
                     ok ? last_period : -1);
        end
        n_checks++;
        if (last_a_len < 1226 || last_a_len > 1231 ||
            last_b_len < 1226 || last_b_len > 1231) begin
            n_fail++;
            $display("FAIL step_pulse got=%0d/%0d want=1228+-2",
                     last_a_len, last_b_len);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_ticks(1, ok);
        clk_n(300);
        bus.freq_in = 20'd41000;
        clk_n(300);
        bus.freq_in = 20'd42000;
        exp_q.push_back(20'd42000);
        cur = 42000;
        wait_ticks(1, ok);
        n_checks++;
        if (!ok || bus.freq_applied !== 20'd42000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_applied got=%0d want=42000",
                     bus.freq_applied);
        end
        wait_ticks(1, ok);
        n_checks++;
        if (!ok || last_period < 2379 || last_period > 2382) begin
            n_fail++;
            $display("FAIL b2b_period got=%0d want=2380..2381+-1",
                     ok ? last_period : -1);
        end
    endtask

    task automatic test_out_of_range();
        bit ok;
        bus.freq_in = 20'd46000;
        clk_n(3);
        n_checks++;
        if (bus.freq_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_err got=%b want=1", bus.freq_err);
        end
        wait_ticks(2, ok);
        n_checks++;
        if (!ok || last_period < 2379 || last_period > 2382) begin
            n_fail++;
            $display("FAIL oor_period got=%0d want=2380..2381+-1",
                     ok ? last_period : -1);
        end
        n_checks++;
        if (bus.freq_applied !== 20'(cur)) begin
            n_fail++;
            $display("FAIL oor_freq got=%0d want=%0d",
                     bus.freq_applied, cur);
        end
        bus.freq_in = 20'(cur);
        clk_n(3);
        n_checks++;
        if (bus.freq_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_sticky got=%b want=1", bus.freq_err);
        end
    endtask

    task automatic test_enable_drop();
        bit got;
        bit saw_b;
        int n;
        got = 1'b0; saw_b = 1'b0; n = 0;
        for (int i = 0; i < 4000; i++) begin
            clk_n(1);
            if (bus.drive_a === 1'b1) begin got = 1'b1; break; end
        end
        bus.enable = 1'b0;
        clk_n(1);
        n_checks++;
        if (!got || bus.drive_a !== 1'b0 || bus.drive_b !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_drive got=%b%b want=00",
                     bus.drive_a, bus.drive_b);
        end
        n_checks++;
        if (bus.freq_err !== 1'b0 || bus.freq_applied !== 20'(cur)) begin
            n_fail++;
            $display("FAIL drop_state got=%b/%0d want=0/%0d",
                     bus.freq_err, bus.freq_applied, cur);
        end
        clk_n(3);
        bus.enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            clk_n(1);
            n++;
            if (bus.drive_b === 1'b1) saw_b = 1'b1;
            if (bus.drive_a === 1'b1) break;
        end
        n_checks++;
        if (n != DEAD_CYC + 1 || saw_b) begin
            n_fail++;
            $display("FAIL reenable_latency got=%0d want=%0d",
                     n, DEAD_CYC + 1);
        end
    endtask

    task automatic test_start_invalid();
        bit ok;
        bus.enable = 1'b0;
        clk_n(2);
        bus.freq_in = 20'd0;
        bus.enable = 1'b1;
        clk_n(1);
        n_checks++;
        if (bus.freq_applied !== 20'd35000 || bus.freq_err !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_start got=%0d/%b want=35000/1",
                     bus.freq_applied, bus.freq_err);
        end
        wait_ticks(3, ok);
        n_checks++;
        if (!ok || last_period < 2856 || last_period > 2858) begin
            n_fail++;
            $display("FAIL inv_period got=%0d want=2857+-1",
                     ok ? last_period : -1);
        end
    endtask

    task automatic test_random();
        bit saw_err;
        int f;
        bus.enable = 1'b0;
        clk_n(2);
        bus.freq_in = 20'd40000;
        cur = 40000;
        saw_err = 1'b0;
        bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk_n(int'($urandom_range(3000, 4000)));
            f = int'($urandom_range(34000, 46000));
            if (f < 35000 || f > 45000) begin
                saw_err = 1'b1;
            end else if (f != cur) begin
                exp_q.push_back(20'(f));
                cur = f;
            end
            bus.freq_in = 20'(f);
        end
        clk_n(3000);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_pending got=%0d want=0", exp_q.size());
        end
        n_checks++;
        if (bus.freq_applied !== 20'(cur) || bus.freq_err !== saw_err) begin
            n_fail++;
            $display("FAIL rand_final got=%0d/%b want=%0d/%b",
                     bus.freq_applied, bus.freq_err, cur, saw_err);
        end
    endtask

    task automatic test_reset_mid();
        nrst = 1'b0;
        clk_n(1);
        n_checks++;
        if (bus.drive_a !== 1'b0 || bus.drive_b !== 1'b0 ||
            bus.freq_applied !== 20'd35000) begin
            n_fail++;
            $display("FAIL mid_reset got=%b%b/%0d want=00/35000",
                     bus.drive_a, bus.drive_b, bus.freq_applied);
        end
        nrst = 1'b1;
        bus.enable = 1'b0;
        clk_n(2);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_start();
        test_sweep_step();
        test_back_to_back();
        test_out_of_range();
        test_enable_drop();
        test_start_invalid();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/swipt_drive_gen.md
Name: swipt_drive_gen

Overview:
- Transmit-side consumer of the frequency-sweep block's `newFreq` output.
- Converts a requested drive frequency in Hz into a complementary, dead-time-protected square-wave pair that drives the SWIPT transmitter half-bridge.
- Uses a phase-accumulator NCO.
- Frequency changes take effect only at a period boundary, so the sweep never produces a runt pulse on the coil.

Parameters:
- CLK_HZ, 100000000: system clock frequency; documents the INC_MULT derivation.
- ACC_W, 32: phase accumulator width.
- INC_MULT, 2814750: round(2^(ACC_W+16)/CLK_HZ); phase increment = (freq*INC_MULT)>>16.
- FREQ_MIN, 20'h88B8: lowest accepted frequency, 35000 Hz.
- FREQ_MAX, 20'hAFC8: highest accepted frequency, 45000 Hz.
- FREQ_DEFAULT, 20'h88B8: frequency used after reset or when the start request is invalid.
- DEAD_CYC, 20: dead-time clocks between one switch turning off and the other turning on (200 ns).

Ports:
- clk, in, 1: system clock.
- nrst, in, 1: reset; synchronous, active-low.
- enable, in, 1: drive enable, tied to swiptAlive.
- freq_in, in, 20: requested frequency in Hz (sweep newFreq); level-held, no valid strobe.
- drive_a, out, 1: high-side gate.
- drive_b, out, 1: low-side gate.
- freq_applied, out, 20: frequency currently generated.
- period_tick, out, 1: 1-clk pulse on each accumulator wrap (start of period).
- freq_switched, out, 1: 1-clk pulse when a new frequency is applied.
- freq_err, out, 1: sticky flag, freq_in was out of range; cleared by reset or enable low.

Behaviour:
- Reset (nrst=0 at posedge), all registered:
  - drive_a=0, drive_b=0.
  - freq_applied=FREQ_DEFAULT, inc=inc(FREQ_DEFAULT).
  - phase=0, period_tick=0, freq_switched=0, freq_err=0.
  - FSM=OFF, dead counter=0.
- Increment: inc = (freq*INC_MULT)>>16, unsigned.
  - Product is 42 bits; result is truncated to ACC_W.
  - Examples: 40000 Hz -> 1717987; 35000 Hz -> 1503238.
- Accumulator: phase <= phase + inc while not OFF.
  - wrap = carry out of the ACC_W add.
  - sq = phase[ACC_W-1].
- Range check: a value is valid iff FREQ_MIN <= freq_in <= FREQ_MAX.
- Frequency update, checked every clk while running:
  - If freq_in != freq_applied and freq_in is valid: latch it into pending and set pend_flag; a newer valid value overwrites pending.
  - If freq_in is invalid: set freq_err and leave pending unchanged.
  - On the wrap cycle with pend_flag set: freq_applied<=pending, inc<=inc(pending), pend_flag<=0, and freq_switched pulses in the same cycle as period_tick.
  - The new inc is used from the following clk.
  - A freq_in change arriving on the wrap cycle itself is held for the next wrap.
- FSM states: OFF, A_ON, DEAD_AB, B_ON, DEAD_BA.
- OFF:
  - Both outputs 0; phase held at 0.
  - On enable=1, go to DEAD_BA with the dead counter loaded.
  - Load freq_applied from freq_in if valid; otherwise load FREQ_DEFAULT and set freq_err.
  - This gives guaranteed dead time before the first A pulse.
- DEAD_BA: both 0. Counter decrements; at 0 go to A_ON if sq=0, else B_ON.
- A_ON: drive_a=1. When sq becomes 1, go to DEAD_AB and load the counter.
- DEAD_AB: both 0. Counter decrements; at 0 go to B_ON if sq=1, else A_ON.
- B_ON: drive_b=1. When sq becomes 0, go to DEAD_BA and load the counter.
- If sq toggles while a dead counter is running, the counter continues; at expiry the target state is chosen from the current sq.
- Outputs are registered decodes of the next state. drive_a and drive_b are never both 1 in any cycle; this is an assertion target.
- enable falling, any state:
  - Next clk: OFF, both outputs 0, phase=0, pend_flag=0, freq_err=0.
  - freq_applied is retained.
  - No period completion is waited for.
- nrst low mid-operation: identical to reset, at the next posedge.
- Latency: the drive edge trails the sq edge by exactly DEAD_CYC+1 clks.
- Period: wrap-to-wrap interval is floor or ceil of 2^ACC_W/inc; 2500 +/-1 clk at 40 kHz.

Decomposition:
- Shared package/header (swipt_defs): FREQ_MIN, FREQ_MAX, FREQ_DEFAULT, FREQ_W=20, and the FSM state encoding. The sweep block shares the same frequency constants.
- Sub-module swipt_deadtime: FSM plus dead counter; inputs sq, enable; outputs drive_a, drive_b.
- The top level holds the NCO, range check, pending-frequency logic and the registered increment multiply.

Test Plan:
- Reset, enable=1, freq_in=40000:
  - drive_a rises DEAD_CYC+1 clks after start.
  - period_tick spacing 2500+/-1 clks.
  - drive_a and drive_b each high ~1250-21 clks per period.
  - freq_err=0.
- Sweep step mid-period, freq_in 40000 -> 40050 at cycle 600 of a period:
  - No change until the next period_tick.
  - freq_switched coincides with that tick.
  - freq_applied=40050; next period 2497+/-1 clks.
  - No shortened high or low phase.
- Out of range, freq_in=46000 while running:
  - freq_err=1 (sticky).
  - freq_applied stays 40000.
  - Output period unchanged.
- Start invalid, enable rises with freq_in=0:
  - freq_applied=35000, freq_err=1.
  - Period 2857+/-1 clks.
- enable drops while drive_a=1:
  - Next clk: both outputs 0, phase=0, freq_err=0.
  - Re-enable: dead time precedes the first drive_a.
- Random freq_in changes every 1-5000 clks across 34000-46000, 10^6 clks:
  - Assert never (drive_a && drive_b).
  - Every on pulse is preceded by >=DEAD_CYC low clks.
